pio_debounce_irq: RTL and testbench
===================================

// Module: pio_debounce_irq
// PURPOSE
//  Parametrised Avalon-MM parallel I/O peripheral for the Nios system, replacing separate switch/LED PIOs.
//  Synchronises and debounces IN_WIDTH switch inputs, drives OUT_WIDTH LED outputs with atomic set/clear.
//  Captures debounced edges per bit and raises a maskable level interrupt to the CPU.
//  Sits on the system interconnect; switches_export/leds_export go to board pins.
// PARAMETERS
//  IN_WIDTH         8      number of switch inputs, 1..32
//  OUT_WIDTH        8      number of LED outputs, 1..32
//  DEBOUNCE_CYCLES  50000  consecutive stable clocks required before a debounced bit changes, >=1
//  EDGE_MODE        0      0 = capture rising, 1 = capture falling, 2 = capture both
//  OUT_RESET        0      reset value of leds_export (OUT_WIDTH bits)
// PORTS
//  clk_clk          in   1          system clock; single clock domain
//  reset_reset      in   1          asynchronous, active-high reset
//  avs_address      in   3          word address of register
//  avs_read         in   1          read strobe
//  avs_write        in   1          write strobe
//  avs_writedata    in   32         write data
//  avs_readdata     out  32         read data, valid 1 cycle after avs_read
//  irq              out  1          level interrupt, high while any unmasked edge bit set
//  switches_export  in   IN_WIDTH   raw asynchronous switch inputs
//  leds_export      out  OUT_WIDTH  LED drive, registered
// BEHAVIOUR
//  Reset (async assert, sync to clk_clk on release): leds_export=OUT_RESET, avs_readdata=0, irq=0,
//   sync flops, debounced value, counters, edge_capture, irq_mask all 0.
//  Register map (unused readdata bits read 0; writes use low bits only):
//   0 DATA    R: debounced inputs; write ignored
//   1 LEDS    RW: LED register
//   2 MASK    RW: irq_mask[IN_WIDTH-1:0]
//   3 EDGE    R: edge_capture; W: write-1-to-clear per bit
//   4 SET     W: LEDS |= wdata; reads 0
//   5 CLR     W: LEDS &= ~wdata; reads 0;  addresses 6,7 read 0, writes ignored
//  Reads: fixed latency 1; avs_readdata registered, holds last value when no read.
//  Writes take effect on the clock edge where avs_write=1; leds_export updates that same edge.
//  Input path per bit: 2-flop synchroniser -> counter -> debounced bit.
//   sync != debounced: counter increments; when counter reaches DEBOUNCE_CYCLES-1 and still differs,
//   debounced toggles and counter clears. sync == debounced: counter clears (glitch discarded).
//   A clean input step appears on DATA exactly DEBOUNCE_CYCLES+2 clock edges after it is sampled.
//   Counter width $clog2(DEBOUNCE_CYCLES+1); never wraps.
//  Edge capture: edge = debounced vs its 1-cycle-delayed copy, filtered by EDGE_MODE; sets bit sticky.
//   Simultaneous new edge and write-1-clear on same bit: set wins (bit stays 1).
//  irq = |(edge_capture & irq_mask), combinational from registers; no extra latency after capture.
//  Input held high through reset release yields a rising debounced edge DEBOUNCE_CYCLES+2 cycles later
//   (captured if EDGE_MODE is 0 or 2); this is intended so software sees initial state as an event.
//  Reset asserted mid-debounce or mid-transaction: all state cleared immediately, pending read data lost.
// TESTING (bench uses DEBOUNCE_CYCLES=4, IN_WIDTH=OUT_WIDTH=8, EDGE_MODE=0)
//  Reset: assert reset_reset mid-cycle -> leds_export=0x00, irq=0, readdata=0 asynchronously.
//  Step switch[0] 0->1 held -> DATA reads 0x01 from edge 6 onward; EDGE bit0=1; MASK=0x01 -> irq=1.
//  Glitch switch[3] high for 3 cycles -> DATA stays 0x00, EDGE stays 0x00, irq stays 0.
//  Write LEDS=0xA5, SET 0x0F, CLR 0x81 -> leds_export 0xA5, 0xAF, 0x2E; read LEDS returns 0x2E.
//  EDGE=0x01, write EDGE 0x01 on same cycle as new rising edge bit0 -> EDGE stays 0x01; next clear -> 0x00, irq=0.
//  Read addresses 4..7 -> readdata 0x00000000 one cycle after avs_read; no state change.

Source files
------------

// File: rtl/pio_debounce_irq_if.sv
// Avalon-MM slave bus bundle for pio_debounce_irq: word address, read/write strobes, data.
interface pio_debounce_irq_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/pio_debounce_irq.sv
// Avalon-MM parallel I/O: synchronised and debounced switch inputs with sticky edge capture
// and maskable level irq, plus an LED register with atomic set/clear aliases.
module pio_debounce_irq #(
    parameter int                   IN_WIDTH        = 8,
    parameter int                   OUT_WIDTH       = 8,
    parameter int                   DEBOUNCE_CYCLES = 50000,
    parameter int                   EDGE_MODE       = 0,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    pio_debounce_irq_if.slave    avs,
    output logic                 irq,
    input  logic [IN_WIDTH-1:0]  switches_export,
    output logic [OUT_WIDTH-1:0] leds_export
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        REG_DATA = 3'd0,
        REG_LEDS = 3'd1,
        REG_MASK = 3'd2,
        REG_EDGE = 3'd3,
        REG_SET  = 3'd4,
        REG_CLR  = 3'd5
    } reg_addr_e;

    reg_addr_e            addr;
    logic [IN_WIDTH-1:0]  wdata_in;
    logic [OUT_WIDTH-1:0] wdata_out;
    logic                 unused_wdata;

    logic [IN_WIDTH-1:0]  sync1_q, sync2_q;
    logic [IN_WIDTH-1:0]  deb_q, deb_d, deb_dly_q;
    logic [CNT_W-1:0]     cnt_q [IN_WIDTH];
    logic [CNT_W-1:0]     cnt_d [IN_WIDTH];
    logic [IN_WIDTH-1:0]  rise, fall, new_edge, edge_clr;
    logic [IN_WIDTH-1:0]  edge_q, edge_d;
    logic [IN_WIDTH-1:0]  mask_q, mask_d;
    logic [OUT_WIDTH-1:0] leds_q, leds_d;
    logic [31:0]          rdata_q, rdata_d;

    assign addr         = reg_addr_e'(avs.avs_address);
    assign wdata_in     = avs.avs_writedata[IN_WIDTH-1:0];
    assign wdata_out    = avs.avs_writedata[OUT_WIDTH-1:0];
    assign unused_wdata = ^avs.avs_writedata;

    // Per-bit debounce: the counter runs only while the synchronised input disagrees with
    // the debounced value; any agreement discards the partial count.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no path
        // leaves a signal unassigned and no latch is inferred.
        deb_d = deb_q;
        for (int i = 0; i < IN_WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        rise = deb_q & ~deb_dly_q;
        fall = ~deb_q & deb_dly_q;
        case (EDGE_MODE)
            0:       new_edge = rise;
            1:       new_edge = fall;
            default: new_edge = rise | fall;
        endcase
    end

    // A fresh edge wins over a simultaneous write-1-to-clear so no event is lost.
    always_comb begin
        edge_clr = (avs.avs_write && addr == REG_EDGE) ? wdata_in : '0;
        edge_d   = (edge_q & ~edge_clr) | new_edge;
    end

    always_comb begin
        leds_d = leds_q;
        mask_d = mask_q;
        if (avs.avs_write) begin
            case (addr)
                REG_LEDS: leds_d = wdata_out;
                REG_MASK: mask_d = wdata_in;
                REG_SET:  leds_d = leds_q | wdata_out;
                REG_CLR:  leds_d = leds_q & ~wdata_out;
                default:  ;
            endcase
        end
    end

    // Read data is registered and holds its last value between reads.
    always_comb begin
        rdata_d = rdata_q;
        if (avs.avs_read) begin
            case (addr)
                REG_DATA: rdata_d = 32'(deb_q);
                REG_LEDS: rdata_d = 32'(leds_q);
                REG_MASK: rdata_d = 32'(mask_q);
                REG_EDGE: rdata_d = 32'(edge_q);
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            edge_q    <= '0;
            mask_q    <= '0;
            leds_q    <= OUT_RESET;
            rdata_q   <= '0;
            // NOTE: the counter array is reset explicitly; it is control state, not a RAM,
            // so a half-finished debounce must not survive reset.
            for (int i = 0; i < IN_WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values;
            // the synchroniser chain depends on that ordering.
            sync1_q   <= switches_export;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            edge_q    <= edge_d;
            mask_q    <= mask_d;
            leds_q    <= leds_d;
            rdata_q   <= rdata_d;
            for (int i = 0; i < IN_WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign irq              = |(edge_q & mask_q);
    assign leds_export      = leds_q;
    assign avs.avs_readdata = rdata_q;

endmodule

// File: tb/tb_pio_debounce_irq.sv
// Self-checking bench for pio_debounce_irq with DEBOUNCE_CYCLES=4, 8-bit ports, rising-edge capture.
module tb_pio_debounce_irq;

    localparam logic [2:0] A_DATA = 3'd0;
    localparam logic [2:0] A_LEDS = 3'd1;
    localparam logic [2:0] A_MASK = 3'd2;
    localparam logic [2:0] A_EDGE = 3'd3;
    localparam logic [2:0] A_SET  = 3'd4;
    localparam logic [2:0] A_CLR  = 3'd5;

    typedef struct {
        logic [31:0] val;
        string       name;
    } exp_t;

    logic       clk;
    logic       reset_reset;
    logic       irq;
    logic [7:0] switches;
    logic [7:0] leds;
    int         total;
    int         bad;
    exp_t       sb[$];

    pio_debounce_irq_if bus();

    pio_debounce_irq #(
        .IN_WIDTH       (8),
        .OUT_WIDTH      (8),
        .DEBOUNCE_CYCLES(4),
        .EDGE_MODE      (0),
        .OUT_RESET      (8'h00)
    ) dut (
        .clk_clk        (clk),
        .reset_reset    (reset_reset),
        .avs            (bus.slave),
        .irq            (irq),
        .switches_export(switches),
        .leds_export    (leds)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "bench stopped by watchdog");
    end

    // Starts at a falling edge; expected data is queued when the strobe is driven and
    // compared once the registered read data appears after the capturing edge.
    task automatic bus_read(input logic [2:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        exp_t got;
        bus.avs_address = addr;
        bus.avs_read    = 1'b1;
        e.val  = exp;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        total++;
        if (bus.avs_readdata !== got.val) begin
            bad++;
            $display("FAIL %s: readdata=0x%08h expected=0x%08h", got.name, bus.avs_readdata, got.val);
        end
        @(negedge clk);
        bus.avs_read = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        bus.avs_address   = addr;
        bus.avs_writedata = data;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        reset_reset = 1'b0;
        @(negedge clk);
        bus_write(A_LEDS, 32'hFF);
        bus_read(A_LEDS, 32'h0000_00FF, "pre_reset_leds");
        #2;
        reset_reset = 1'b1;
        #1;
        total++;
        if (leds !== 8'h00) begin
            bad++;
            $display("FAIL reset_leds: leds=0x%02h expected=0x00", leds);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq: irq=%b expected=0", irq);
        end
        total++;
        if (bus.avs_readdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_readdata: readdata=0x%08h expected=0x00000000", bus.avs_readdata);
        end
        @(negedge clk);
        reset_reset = 1'b0;
        @(negedge clk);
        bus_read(A_DATA, 32'h0, "reset_data");
        bus_read(A_MASK, 32'h0, "reset_mask");
        bus_read(A_EDGE, 32'h0, "reset_edge");
        bus_read(A_LEDS, 32'h0, "reset_leds_reg");
    endtask

    // Three stable cycles are one short of the debounce threshold.
    task automatic test_glitch();
        bus_write(A_MASK, 32'hFF);
        switches[3] = 1'b1;
        repeat (3) @(negedge clk);
        switches[3] = 1'b0;
        repeat (10) @(negedge clk);
        bus_read(A_DATA, 32'h0, "glitch_data");
        bus_read(A_EDGE, 32'h0, "glitch_edge");
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL glitch_irq: irq=%b expected=0", irq);
        end
    endtask

    // Step sampled at edge 1 is debounced at edge 6: a read captured at edge 5 still sees 0,
    // one captured at edge 7 sees 1, and the edge bit is set by edge 7.
    task automatic test_step();
        bus_write(A_MASK, 32'h00);
        switches[0] = 1'b1;
        repeat (4) @(negedge clk);
        bus_read(A_DATA, 32'h0, "step_data_edge5");
        @(negedge clk);
        bus_read(A_DATA, 32'h1, "step_data_edge7");
        bus_read(A_EDGE, 32'h1, "step_edge");
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL step_irq_masked: irq=%b expected=0", irq);
        end
        bus_write(A_MASK, 32'h01);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL step_irq_unmasked: irq=%b expected=1", irq);
        end
    endtask

    task automatic test_leds();
        bus_write(A_LEDS, 32'hA5);
        total++;
        if (leds !== 8'hA5) begin
            bad++;
            $display("FAIL leds_write: leds=0x%02h expected=0xa5", leds);
        end
        bus_write(A_SET, 32'h0F);
        total++;
        if (leds !== 8'hAF) begin
            bad++;
            $display("FAIL leds_set: leds=0x%02h expected=0xaf", leds);
        end
        bus_write(A_CLR, 32'h81);
        total++;
        if (leds !== 8'h2E) begin
            bad++;
            $display("FAIL leds_clr: leds=0x%02h expected=0x2e", leds);
        end
        bus_read(A_LEDS, 32'h0000_002E, "leds_readback");
    endtask

    // A falling debounced edge is not captured; then a new rising edge coincides with a
    // write-1-clear of the same bit and must survive.
    task automatic test_edge_clear();
        switches[0] = 1'b0;
        repeat (10) @(negedge clk);
        bus_read(A_DATA, 32'h0, "fall_data");
        bus_read(A_EDGE, 32'h1, "fall_not_captured");
        switches[0] = 1'b1;
        repeat (6) @(negedge clk);
        bus_write(A_EDGE, 32'h01);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL set_wins_irq: irq=%b expected=1", irq);
        end
        bus_read(A_EDGE, 32'h1, "set_wins_edge");
        bus_write(A_EDGE, 32'h01);
        bus_read(A_EDGE, 32'h0, "edge_cleared");
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL cleared_irq: irq=%b expected=0", irq);
        end
    endtask

    task automatic test_unused_addr();
        bus_write(3'd6, 32'hFF);
        bus_write(3'd7, 32'hFF);
        bus_write(A_DATA, 32'hFF);
        for (int a = 4; a < 8; a++) begin
            bus_read(3'(a), 32'h0, $sformatf("unused_addr%0d", a));
        end
        bus_read(A_LEDS, 32'h0000_002E, "unused_leds_intact");
        bus_read(A_DATA, 32'h1, "data_write_ignored");
        bus_read(A_MASK, 32'h1, "unused_mask_intact");
        repeat (2) @(negedge clk);
        total++;
        if (bus.avs_readdata !== 32'h1) begin
            bad++;
            $display("FAIL readdata_hold: readdata=0x%08h expected=0x00000001", bus.avs_readdata);
        end
        total++;
        if (leds !== 8'h2E) begin
            bad++;
            $display("FAIL unused_leds_pins: leds=0x%02h expected=0x2e", leds);
        end
    endtask

    initial begin
        total             = 0;
        bad               = 0;
        reset_reset       = 1'b1;
        switches          = 8'h00;
        bus.avs_address   = 3'd0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = 32'h0;

        test_reset();
        test_glitch();
        test_step();
        test_leds();
        test_edge_clear();
        test_unused_addr();

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
